// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller sitting between the PC register
// and instruction memory. Issues in-order req/gnt/rvalid fetches, tags every
// request with its address, buffers tagged responses for decode and throws
// away buffered and in-flight work when execute redirects the stream.
// DEPTH must be a power of two and at least 2.

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  // Pointer width and counter width (counters must be able to hold DEPTH).
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] LP_PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LP_CNT_ZERO = '0;
  localparam logic [CW:0]   LP_DEPTH_X  = (CW + 1)'(DEPTH);

  // Outstanding requests, responses still to be discarded, FIFO occupancy.
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;

  // Tag queue: address of every request granted but not yet answered.
  logic [31:0]   r_tagMem [DEPTH];
  logic [AW-1:0] r_tagWr;
  logic [AW-1:0] r_tagRd;

  // Instruction FIFO: {pc, data} pairs waiting for decode.
  logic [31:0]   r_pcMem   [DEPTH];
  logic [31:0]   r_dataMem [DEPTH];
  logic [AW-1:0] r_fifoWr;
  logic [AW-1:0] r_fifoRd;

  logic [CW:0]   w_credit;
  logic          w_accept;
  logic          w_rvalidOk;
  logic          w_discard;
  logic          w_fifoPush;
  logic          w_fifoPop;
  logic [31:0]   w_tagHead;
  logic [31:0]   w_pcPlus4;
  logic [CW-1:0] w_outstNext;
  logic [CW-1:0] w_dropNext;
  logic [CW-1:0] w_countNext;

  // Credit covers both in-flight requests and buffered instructions, so a
  // granted request always has a FIFO slot waiting for its response.
  assign w_credit   = {1'b0, r_outst} + {1'b0, r_count};
  assign imem_req   = !rst && !redirect && (w_credit < LP_DEPTH_X);
  assign imem_addr  = pc_cur & 32'hFFFF_FFFC;
  assign w_accept   = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rvalidOk = imem_rvalid && (r_outst != LP_CNT_ZERO);
  assign w_discard  = (r_drop != LP_CNT_ZERO) || redirect;
  assign w_fifoPush = w_rvalidOk && !w_discard;
  assign w_fifoPop  = inst_valid && inst_ready && !redirect;
  assign w_tagHead  = r_tagMem[r_tagRd];
  assign w_pcPlus4  = pc_cur + 32'd4;

  assign inst_valid = (r_count != LP_CNT_ZERO);
  assign inst_data  = r_dataMem[r_fifoRd];
  assign inst_pc    = r_pcMem[r_fifoRd];

  // Next-PC select; holding pc_cur keeps the request address stable until grant.
  always_comb begin
    pc_next = pc_cur;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (redirect) begin
      pc_next = redirect_pc & 32'hFFFF_FFFC;
    end else if (w_accept) begin
      pc_next = w_pcPlus4;
    end
  end

  // Next values for the outstanding, drop and occupancy counters.
  always_comb begin
    w_outstNext = r_outst;
    if (w_accept && !w_rvalidOk) begin
      w_outstNext = r_outst + LP_CNT_ONE;
    end else if (!w_accept && w_rvalidOk) begin
      w_outstNext = r_outst - LP_CNT_ONE;
    end

    w_dropNext = r_drop;
    if (redirect) begin
      w_dropNext = w_rvalidOk ? (r_outst - LP_CNT_ONE) : r_outst;
    end else if (w_rvalidOk && (r_drop != LP_CNT_ZERO)) begin
      w_dropNext = r_drop - LP_CNT_ONE;
    end

    w_countNext = r_count;
    if (redirect) begin
      w_countNext = LP_CNT_ZERO;
    end else if (w_fifoPush && !w_fifoPop) begin
      w_countNext = r_count + LP_CNT_ONE;
    end else if (!w_fifoPush && w_fifoPop) begin
      w_countNext = r_count - LP_CNT_ONE;
    end
  end

  // Register the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outst <= LP_CNT_ZERO;
      r_drop  <= LP_CNT_ZERO;
      r_count <= LP_CNT_ZERO;
    end else begin
      r_outst <= w_outstNext;
      r_drop  <= w_dropNext;
      r_count <= w_countNext;
    end
  end

  // Tag queue: push the address on grant, pop on every accepted response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tagWr <= '0;
      r_tagRd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tagMem[i] <= 32'h0;
      end
    end else begin
      if (w_accept) begin
        r_tagMem[r_tagWr] <= imem_addr;
        r_tagWr           <= r_tagWr + LP_PTR_ONE;
      end
      if (w_rvalidOk) begin
        r_tagRd <= r_tagRd + LP_PTR_ONE;
      end
    end
  end

  // Instruction FIFO pointers; a redirect empties the FIFO outright.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_fifoWr <= '0;
      r_fifoRd <= '0;
    end else begin
      if (w_fifoPush) begin
        r_fifoWr <= r_fifoWr + LP_PTR_ONE;
      end
      if (w_fifoPop) begin
        r_fifoRd <= r_fifoRd + LP_PTR_ONE;
      end
    end
  end

  // Instruction FIFO storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pcMem[i]   <= 32'h0;
        r_dataMem[i] <= 32'h0;
      end
    end else if (w_fifoPush) begin
      r_pcMem[r_fifoWr]   <= w_tagHead;
      r_dataMem[r_fifoWr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a PC register, an in-order
// memory model and a scoreboard of expected {pc, data} deliveries to decode.

module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        respOn;
  logic [31:0] pending[$];
  logic [31:0] expQ[$];
  int          nVectors;
  int          nFail;
  int          grants;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .pc_next    (pc_next),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register fed by pc_next.
  initial pc_cur = 32'h0;
  always_ff @(posedge clk) pc_cur <= pc_next;

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] memData(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one cycle: record the handshakes of this cycle in the memory
  // model, then present the next in-order response (if enabled).
  task automatic applyStimulus();
    #1;
    if (rst) begin
      pending.delete();
    end else begin
      if (imem_rvalid && pending.size() > 0) void'(pending.pop_front());
      if (imem_req && imem_gnt) pending.push_back(imem_addr);
    end
    @(posedge clk);
    #1;
    if (respOn && pending.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memData(pending[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic drain(input int n);
    imem_gnt   = 1'b0;
    inst_ready = 1'b1;
    respOn     = 1'b1;
    repeat (n) applyStimulus();
  endtask

  // Monitor: every instruction decode accepts must match the scoreboard head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready && !redirect) begin
        if (expQ.size() == 0) begin
          nVectors++;
          nFail++;
          $display("[TB] FAIL mon_unexpected: got pc 0x%08h, expected no delivery", inst_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("mon_pc", inst_pc, e);
          checkOutput("mon_data", inst_data, memData(e));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    nVectors = 0; nFail = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0; respOn = 1'b1;

    // Reset values.
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_pc_next", pc_next, 32'h0);
    checkOutput("rst_valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("rst_data", inst_data, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);

    // Stream from reset with zero-wait memory.
    rst = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1;
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    expQ.push_back(32'h8); expQ.push_back(32'hC);
    #1;
    checkOutput("c0_req", {31'h0, imem_req}, 32'h1);
    checkOutput("c0_addr", imem_addr, 32'h0);
    checkOutput("c0_pc_next", pc_next, 32'h4);
    applyStimulus(); #1;
    checkOutput("c1_valid", {31'h0, inst_valid}, 32'h0);
    applyStimulus(); #1;
    checkOutput("c2_valid", {31'h0, inst_valid}, 32'h1);
    checkOutput("c2_inst_pc", inst_pc, 32'h0);
    applyStimulus(); #1;
    checkOutput("c3_inst_pc", inst_pc, 32'h4);

    // Grant stall at 0x10.
    applyStimulus();
    imem_gnt = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_addr", imem_addr, 32'h10);
      checkOutput("stall_pc_next", pc_next, 32'h10);
      applyStimulus(); #1;
    end
    imem_gnt = 1'b1;
    expQ.push_back(32'h10);
    #1;
    checkOutput("stall_grant_pc_next", pc_next, 32'h14);
    applyStimulus();
    drain(4);

    // Backpressure: four grants fill the credit, then one pop frees one slot.
    inst_ready = 1'b0; imem_gnt = 1'b1; grants = 0;
    expQ.push_back(32'h14); expQ.push_back(32'h18);
    expQ.push_back(32'h1C); expQ.push_back(32'h20);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (imem_req && imem_gnt) grants++;
      applyStimulus();
    end
    #1;
    checkOutput("bp_grants", grants, 32'd4);
    checkOutput("bp_req_full", {31'h0, imem_req}, 32'h0);
    inst_ready = 1'b1;
    applyStimulus();
    inst_ready = 1'b0;
    expQ.push_back(32'h24);
    #1;
    checkOutput("bp_req_freed", {31'h0, imem_req}, 32'h1);
    checkOutput("bp_addr_freed", imem_addr, 32'h24);
    applyStimulus(); #1;
    checkOutput("bp_req_refull", {31'h0, imem_req}, 32'h0);
    drain(8);

    // Redirect with two requests in flight and one buffered instruction.
    inst_ready = 1'b0; imem_gnt = 1'b1; respOn = 1'b1;
    applyStimulus();
    respOn = 1'b0;
    applyStimulus();
    applyStimulus();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1; respOn = 1'b1;
    #1;
    checkOutput("rd_valid_before", {31'h0, inst_valid}, 32'h1);
    checkOutput("rd_pc_next", pc_next, 32'h200);
    checkOutput("rd_req", {31'h0, imem_req}, 32'h0);
    applyStimulus();
    redirect = 1'b0; imem_gnt = 1'b1;
    expQ.push_back(32'h200);
    #1;
    checkOutput("rd_flushed", {31'h0, inst_valid}, 32'h0);
    checkOutput("rd_first_req", {31'h0, imem_req}, 32'h1);
    checkOutput("rd_first_addr", imem_addr, 32'h200);
    applyStimulus();
    imem_gnt = 1'b0;
    #1;
    checkOutput("rd_drop1", {31'h0, inst_valid}, 32'h0);
    applyStimulus(); #1;
    checkOutput("rd_drop2", {31'h0, inst_valid}, 32'h0);
    applyStimulus(); #1;
    checkOutput("rd_deliver_valid", {31'h0, inst_valid}, 32'h1);
    checkOutput("rd_deliver_pc", inst_pc, 32'h200);
    drain(4);

    // Redirect in the same cycle as an rvalid and a pop; misaligned target.
    inst_ready = 1'b0; imem_gnt = 1'b1; respOn = 1'b1;
    applyStimulus();
    respOn = 1'b0;
    applyStimulus();
    respOn = 1'b1;
    applyStimulus();
    imem_gnt = 1'b0; inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    checkOutput("rv_valid_before", {31'h0, inst_valid}, 32'h1);
    checkOutput("rv_pc_next_align", pc_next, 32'h100);
    applyStimulus();
    redirect = 1'b0; imem_gnt = 1'b1;
    expQ.push_back(32'h100);
    #1;
    checkOutput("rv_flushed", {31'h0, inst_valid}, 32'h0);
    checkOutput("rv_first_addr", imem_addr, 32'h100);
    applyStimulus();
    imem_gnt = 1'b0;
    #1;
    checkOutput("rv_no_survivor", {31'h0, inst_valid}, 32'h0);
    applyStimulus(); #1;
    checkOutput("rv_deliver_valid", {31'h0, inst_valid}, 32'h1);
    checkOutput("rv_deliver_pc", inst_pc, 32'h100);
    drain(4);

    // Wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    applyStimulus();
    redirect = 1'b0; imem_gnt = 1'b1;
    expQ.push_back(32'hFFFF_FFFC);
    #1;
    checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_next", pc_next, 32'h0);
    applyStimulus();
    imem_gnt = 1'b0;
    #1;
    checkOutput("wrap_addr_after", imem_addr, 32'h0);
    checkOutput("wrap_pc_hold", pc_next, 32'h0);
    drain(6);

    #1;
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule
